// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - ROM and processor instruction-port bundle
interface instr_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_rdata;
  logic              done;
  logic [8:0]        din;
  logic              run;

  modport master (
    output mem_addr,
    output din,
    output run,
    input  mem_rdata,
    input  done
  );

  modport slave (
    input  mem_addr,
    input  din,
    input  run,
    output mem_rdata,
    output done
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches ROM words and issues them to the processor
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  instr_sequencer_if.master   bus,
  output logic                busy,
  output logic                halted,
  output logic [1:0]          err,
  output logic [ADDR_W-1:0]   pc,
  output logic [15:0]         retired
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_SETUP,
    S_ISSUE,
    S_IMM_LD,
    S_IMM_RUN,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t            state;
  logic              mvi_r;
  logic [7:0]        wait_cnt;
  logic [2:0]        op;
  logic [ADDR_W-1:0] pc_next;

  // ROM data is only decoded in CAPT, where it reflects the address set on entry to ADDR
  assign op      = bus.mem_rdata[8:6];
  assign pc_next = mvi_r ? pc + ADDR_W'(2) : pc + ADDR_W'(1);

  // Sequencer FSM; every output is a register updated on the transition that needs it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      bus.mem_addr <= '0;
      bus.din      <= '0;
      bus.run      <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      err          <= ERR_NONE;
      pc           <= '0;
      retired      <= '0;
      mvi_r        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      // run is a single-cycle strobe: only the SETUP and IMM_LD exits raise it
      bus.run <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state        <= S_ADDR;
            pc           <= '0;
            bus.mem_addr <= '0;
            err          <= ERR_NONE;
            busy         <= 1'b1;
            halted       <= 1'b0;
          end
        end
        S_ADDR: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          if (op == 3'b111) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (op[2]) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            err    <= ERR_ILLEGAL;
          end else begin
            bus.din <= bus.mem_rdata;
            mvi_r   <= (op == 3'b001);
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          // point the ROM at the immediate now so it is readable in IMM_LD
          state   <= S_ISSUE;
          bus.run <= 1'b1;
          if (mvi_r) begin
            bus.mem_addr <= pc + ADDR_W'(1);
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= mvi_r ? S_IMM_LD : S_WAIT;
        end
        S_IMM_LD: begin
          bus.din <= bus.mem_rdata;
          bus.run <= 1'b1;
          state   <= S_IMM_RUN;
        end
        S_IMM_RUN: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // done on the last allowed cycle still retires the instruction
          if (bus.done) begin
            state        <= S_ADDR;
            pc           <= pc_next;
            bus.mem_addr <= pc_next;
            retired      <= retired + 16'd1;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            err    <= ERR_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              halted;
  logic [1:0]        err;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       retired;

  instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .err     (err),
    .pc      (pc),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] rom [32];

  // Synchronous program ROM: data follows the address by one clock
  always @(posedge clk) bus.mem_rdata <= rom[bus.mem_addr];

  // Processor model: answers done after a per-opcode number of WAIT cycles
  logic       done_r = 1'b0;
  logic       active = 1'b0;
  logic       imm_pending = 1'b0;
  logic       run_prev = 1'b0;
  logic [2:0] cur_op = 3'b000;
  logic [8:0] last_run_din = '0;
  int         wcnt = 0;
  int         dly;
  int         override = -1;
  int         run_count = 0;
  int         run_in_wait = 0;
  int         run_wide = 0;

  assign bus.done = done_r;

  always @(negedge clk) begin
    if (!resetn) begin
      done_r      = 1'b0;
      active      = 1'b0;
      imm_pending = 1'b0;
      run_prev    = 1'b0;
      wcnt        = 0;
    end else begin
      if (done_r) done_r = 1'b0;
      if (bus.run) begin
        run_count++;
        last_run_din = bus.din;
        if (active) run_in_wait++;
        if (run_prev) run_wide++;
        if (!imm_pending && bus.din[8:6] == 3'b001) begin
          imm_pending = 1'b1;
          cur_op      = 3'b001;
        end else begin
          if (!imm_pending) cur_op = bus.din[8:6];
          imm_pending = 1'b0;
          active      = 1'b1;
          wcnt        = 1;
        end
      end else if (active) begin
        dly = (override >= 0) ? override : ((cur_op == 3'b010 || cur_op == 3'b011) ? 3 : 1);
        if (dly != 0 && wcnt == dly) begin
          done_r = 1'b1;
          active = 1'b0;
        end else begin
          wcnt++;
        end
      end
      run_prev = bus.run;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 32; i++) rom[i] = w;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    override = -1;
    cycles(2);
    resetn = 1'b1;
    run_count = 0;
    run_in_wait = 0;
    run_wide = 0;
    cycles(1);
  endtask

  // Leaves the bench at the negedge of the ADDR cycle (cycle 1)
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_wait: halted=%b after %0d cycles, want 1", halted, n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cycles(2);
    #1;
    vectors++; if (bus.run !== 1'b0) begin miscompares++; $display("FAIL reset_run: got %b want 0", bus.run); end
    vectors++; if (bus.mem_addr !== 5'd0) begin miscompares++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
    vectors++; if (bus.din !== 9'd0) begin miscompares++; $display("FAIL reset_din: got %o want 0", bus.din); end
    vectors++; if (busy !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL reset_busy_halted: got %b%b want 00", busy, halted); end
    vectors++; if (err !== 2'b00 || pc !== 5'd0 || retired !== 16'd0) begin miscompares++; $display("FAIL reset_err_pc_retired: got %b %0d %0d want 00 0 0", err, pc, retired); end
    do_reset();
    cycles(3);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_start: busy=%b want 0", busy); end
  endtask

  task automatic test_mv();
    do_reset();
    fill_rom(9'o700);
    rom[0] = 9'o010;
    pulse_start();
    vectors++; if (busy !== 1'b1 || bus.mem_addr !== 5'd0) begin miscompares++; $display("FAIL mv_addr: busy=%b mem_addr=%0d want 1 0", busy, bus.mem_addr); end
    cycles(2);
    vectors++; if (bus.din !== 9'o010 || bus.run !== 1'b0) begin miscompares++; $display("FAIL mv_setup: din=%o run=%b want 010 0", bus.din, bus.run); end
    cycles(1);
    vectors++; if (bus.din !== 9'o010 || bus.run !== 1'b1) begin miscompares++; $display("FAIL mv_issue: din=%o run=%b want 010 1", bus.din, bus.run); end
    cycles(1);
    vectors++; if (bus.run !== 1'b0) begin miscompares++; $display("FAIL mv_wait_run: got %b want 0", bus.run); end
    wait_halt(50);
    vectors++; if (retired !== 16'd1 || pc !== 5'd1) begin miscompares++; $display("FAIL mv_retire: retired=%0d pc=%0d want 1 1", retired, pc); end
    vectors++; if (err !== 2'b00 || run_count != 1) begin miscompares++; $display("FAIL mv_err_runs: err=%b runs=%0d want 00 1", err, run_count); end
  endtask

  task automatic test_mvi();
    do_reset();
    fill_rom(9'o700);
    rom[0] = 9'o120;
    rom[1] = 9'h05A;
    pulse_start();
    cycles(3);
    vectors++; if (bus.run !== 1'b1 || bus.din !== 9'o120) begin miscompares++; $display("FAIL mvi_issue: run=%b din=%o want 1 120", bus.run, bus.din); end
    cycles(1);
    vectors++; if (bus.run !== 1'b0 || bus.din !== 9'o120) begin miscompares++; $display("FAIL mvi_imm_ld: run=%b din=%o want 0 120", bus.run, bus.din); end
    cycles(1);
    vectors++; if (bus.run !== 1'b1 || bus.din !== 9'h05A) begin miscompares++; $display("FAIL mvi_imm_run: run=%b din=%h want 1 05a", bus.run, bus.din); end
    cycles(1);
    vectors++; if (bus.run !== 1'b0 || bus.din !== 9'h05A) begin miscompares++; $display("FAIL mvi_wait: run=%b din=%h want 0 05a", bus.run, bus.din); end
    wait_halt(50);
    vectors++; if (pc !== 5'd2 || retired !== 16'd1) begin miscompares++; $display("FAIL mvi_retire: pc=%0d retired=%0d want 2 1", pc, retired); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_rom(9'o700);
    rom[0] = 9'o130;
    rom[1] = 9'd7;
    rom[2] = 9'o201;
    rom[3] = 9'o310;
    pulse_start();
    wait_halt(200);
    vectors++; if (retired !== 16'd3 || err !== 2'b00 || pc !== 5'd4) begin miscompares++; $display("FAIL prog_result: retired=%0d err=%b pc=%0d want 3 00 4", retired, err, pc); end
    vectors++; if (run_count != 4 || run_in_wait != 0 || run_wide != 0) begin miscompares++; $display("FAIL prog_run: runs=%0d in_wait=%0d wide=%0d want 4 0 0", run_count, run_in_wait, run_wide); end
  endtask

  task automatic test_illegal();
    do_reset();
    fill_rom(9'o700);
    rom[0] = 9'o400;
    pulse_start();
    wait_halt(50);
    vectors++; if (err !== 2'b01 || run_count != 0) begin miscompares++; $display("FAIL illegal_err: err=%b runs=%0d want 01 0", err, run_count); end
    rom[0] = 9'o010;
    pulse_start();
    vectors++; if (err !== 2'b00 || halted !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL illegal_restart: err=%b halted=%b busy=%b want 00 0 1", err, halted, busy); end
    wait_halt(50);
    vectors++; if (retired !== 16'd1 || err !== 2'b00 || pc !== 5'd1) begin miscompares++; $display("FAIL illegal_rerun: retired=%0d err=%b pc=%0d want 1 00 1", retired, err, pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    fill_rom(9'o700);
    rom[0] = 9'o010;
    override = 0;
    pulse_start();
    cycles(3 + TIMEOUT);
    vectors++; if (halted !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL timeout_early: halted=%b busy=%b want 0 1", halted, busy); end
    cycles(1);
    vectors++; if (halted !== 1'b1 || err !== 2'b10 || retired !== 16'd0) begin miscompares++; $display("FAIL timeout_halt: halted=%b err=%b retired=%0d want 1 10 0", halted, err, retired); end
    do_reset();
    override = TIMEOUT;
    pulse_start();
    cycles(3 + TIMEOUT + 1);
    vectors++; if (halted !== 1'b0 || err !== 2'b00 || pc !== 5'd1) begin miscompares++; $display("FAIL timeout_last_done: halted=%b err=%b pc=%0d want 0 00 1", halted, err, pc); end
    wait_halt(50);
    vectors++; if (retired !== 16'd1 || err !== 2'b00) begin miscompares++; $display("FAIL timeout_last_retire: retired=%0d err=%b want 1 00", retired, err); end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    fill_rom(9'o010);
    rom[0]  = 9'o050;
    rom[31] = 9'o140;
    pulse_start();
    while (run_count < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rom[1] = 9'o700;
    wait_halt(1000);
    vectors++; if (pc !== 5'd1 || retired !== 16'd32) begin miscompares++; $display("FAIL wrap_pc: pc=%0d retired=%0d want 1 32", pc, retired); end
    vectors++; if (run_count != 33 || last_run_din !== 9'o050) begin miscompares++; $display("FAIL wrap_imm: runs=%0d last_din=%o want 33 050", run_count, last_run_din); end
  endtask

  task automatic test_reset_abort();
    fill_rom(9'o700);
    rom[0] = 9'o120;
    rom[1] = 9'h05A;
    pulse_start();
    cycles(4);
    vectors++; if (bus.din !== 9'o120 || bus.mem_addr !== 5'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre: din=%o mem_addr=%0d busy=%b want 120 1 1", bus.din, bus.mem_addr, busy); end
    resetn = 1'b0;
    #1;
    vectors++; if (bus.din !== 9'd0 || bus.mem_addr !== 5'd0 || bus.run !== 1'b0) begin miscompares++; $display("FAIL abort_bus: din=%o mem_addr=%0d run=%b want 0 0 0", bus.din, bus.mem_addr, bus.run); end
    vectors++; if (busy !== 1'b0 || halted !== 1'b0 || err !== 2'b00 || pc !== 5'd0 || retired !== 16'd0) begin miscompares++; $display("FAIL abort_status: busy=%b halted=%b err=%b pc=%0d retired=%0d want 0 0 00 0 0", busy, halted, err, pc, retired); end
    @(negedge clk);
    resetn = 1'b1;
    cycles(3);
    vectors++; if (busy !== 1'b0 || bus.run !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy=%b run=%b want 0 0", busy, bus.run); end
    pulse_start();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_restart: busy=%b want 1", busy); end
  endtask

  initial begin
    fill_rom(9'o700);
    test_reset();
    test_mv();
    test_mvi();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_wrap();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
